// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (core A, loader/DMA B) arbiter for the single-port data memory
// Optional MEM_ARB_FIXED_PRIO_EN: ST_ARB conflicts always go to port A instead of round-robin.
module mem_arbiter #(
    parameter int p_WORD_LEN = 16,
    parameter int p_ADDR_LEN = 10,
    parameter int p_MAX_LOCK = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic                  i_a_req,
    input  logic                  i_a_wr_en,
    input  logic [15:0]           i_a_addr,
    input  logic [p_WORD_LEN-1:0] i_a_wr_data,
    output logic                  o_a_gnt,
    output logic                  o_a_rvalid,
    output logic [p_WORD_LEN-1:0] o_a_rd_data,

    input  logic                  i_b_req,
    input  logic                  i_b_wr_en,
    input  logic [15:0]           i_b_addr,
    input  logic [p_WORD_LEN-1:0] i_b_wr_data,
    input  logic                  i_b_lock,
    output logic                  o_b_gnt,
    output logic                  o_b_rvalid,
    output logic [p_WORD_LEN-1:0] o_b_rd_data,

    output logic [p_ADDR_LEN-1:0] o_mem_addr,
    output logic                  o_mem_wr_en,
    output logic [p_WORD_LEN-1:0] o_mem_wr_data,
    input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
    output logic                  o_oob
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK  = 2'd1,
        ST_YIELD = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(p_MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(p_MAX_LOCK);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic             gnt_a, gnt_b;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic             last_b, last_b_nxt;
`endif

    logic             any_gnt;
    logic             sel_wr_en;
    logic [15:0]      sel_addr;
    logic [p_WORD_LEN-1:0] sel_wr_data;
    logic             sel_oob;
    logic [p_WORD_LEN-1:0] rd_value;
    logic             a_read, b_read;

    always_comb begin
        gnt_a        = 1'b0;
        gnt_b        = 1'b0;
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_b_nxt   = last_b;
`endif
        unique case (state)
            ST_ARB: begin
                if (i_a_req && i_b_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                    gnt_a = 1'b1;
`else
                    gnt_a = last_b;
                    gnt_b = !last_b;
`endif
                end else begin
                    gnt_a = i_a_req;
                    gnt_b = i_b_req;
                end
                // The ST_ARB grant to B is the first beat of the burst
                if (gnt_b && i_b_lock) begin
                    lock_cnt_nxt = CNT_W'(1);
                    state_nxt    = (i_a_req && p_MAX_LOCK <= 1) ? ST_YIELD : ST_LOCK;
                end
            end
            ST_LOCK: begin
                gnt_b = i_b_req;
                if (!i_b_req || !i_b_lock) begin
                    state_nxt    = ST_ARB;
                    lock_cnt_nxt = '0;
                end else if (i_a_req) begin
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
                    if (lock_cnt_nxt >= MAX_CNT) begin
                        state_nxt = ST_YIELD;
                    end
                end
            end
            ST_YIELD: begin
                gnt_a        = i_a_req;
                state_nxt    = ST_ARB;
                lock_cnt_nxt = '0;
            end
            default: begin
                state_nxt    = ST_ARB;
                lock_cnt_nxt = '0;
            end
        endcase
`ifndef MEM_ARB_FIXED_PRIO_EN
        if (gnt_a) begin
            last_b_nxt = 1'b0;
        end else if (gnt_b) begin
            last_b_nxt = 1'b1;
        end
`endif
    end

    // Reset forces every combinational output low in the same cycle
    assign o_a_gnt = gnt_a & ~i_rst;
    assign o_b_gnt = gnt_b & ~i_rst;
    assign any_gnt = o_a_gnt | o_b_gnt;

    assign sel_addr    = o_b_gnt ? i_b_addr    : i_a_addr;
    assign sel_wr_en   = o_b_gnt ? i_b_wr_en   : i_a_wr_en;
    assign sel_wr_data = o_b_gnt ? i_b_wr_data : i_a_wr_data;
    assign sel_oob     = |(sel_addr >> p_ADDR_LEN);

    assign o_mem_addr    = any_gnt ? sel_addr[p_ADDR_LEN-1:0] : '0;
    assign o_mem_wr_data = any_gnt ? sel_wr_data : '0;
    assign o_mem_wr_en   = any_gnt & sel_wr_en & ~sel_oob;
    assign o_oob         = any_gnt & sel_oob;

    assign rd_value = sel_oob ? '0 : i_mem_rd_data;
    assign a_read   = o_a_gnt & ~i_a_wr_en;
    assign b_read   = o_b_gnt & ~i_b_wr_en;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_ARB;
            lock_cnt    <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_b      <= 1'b1;
`endif
            o_a_rvalid  <= 1'b0;
            o_b_rvalid  <= 1'b0;
            o_a_rd_data <= '0;
            o_b_rd_data <= '0;
        end else begin
            state      <= state_nxt;
            lock_cnt   <= lock_cnt_nxt;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_b     <= last_b_nxt;
`endif
            o_a_rvalid <= a_read;
            o_b_rvalid <= b_read;
            if (a_read) begin
                o_a_rd_data <= rd_value;
            end
            if (b_read) begin
                o_b_rd_data <= rd_value;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction-level model
// Honours MEM_ARB_FIXED_PRIO_EN when the design is built with it.
module tb_mem_arbiter;

    localparam int WL       = 16;
    localparam int AL       = 10;
    localparam int MAX_LOCK = 8;
    localparam int DEPTH    = 1 << AL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_wr_en = 1'b0;
    logic [15:0]   a_addr = '0;
    logic [WL-1:0] a_wr_data = '0;
    logic          b_req = 1'b0, b_wr_en = 1'b0, b_lock = 1'b0;
    logic [15:0]   b_addr = '0;
    logic [WL-1:0] b_wr_data = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [WL-1:0] a_rd_data, b_rd_data;
    logic [AL-1:0] mem_addr;
    logic          mem_wr_en, oob;
    logic [WL-1:0] mem_wr_data, mem_rd_data;

    logic [WL-1:0] mem     [DEPTH];
    logic [WL-1:0] ref_mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    // model state: who won last, burst length seen while A waits, owed turn for A
    int  m_last;
    bit  m_burst;
    int  m_burst_len;
    bit  m_yield_due;
    logic          exp_a_rvalid, exp_b_rvalid;
    logic [WL-1:0] exp_a_rd, exp_b_rd;
    int  last_win;
    logic obs_a_gnt, obs_b_gnt, obs_oob, obs_wr, obs_a_rvalid;
    logic [WL-1:0] obs_a_rd;

    mem_arbiter #(.p_WORD_LEN(WL), .p_ADDR_LEN(AL), .p_MAX_LOCK(MAX_LOCK)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_req(a_req), .i_a_wr_en(a_wr_en), .i_a_addr(a_addr), .i_a_wr_data(a_wr_data),
        .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rd_data(a_rd_data),
        .i_b_req(b_req), .i_b_wr_en(b_wr_en), .i_b_addr(b_addr), .i_b_wr_data(b_wr_data),
        .i_b_lock(b_lock), .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rd_data(b_rd_data),
        .o_mem_addr(mem_addr), .o_mem_wr_en(mem_wr_en), .o_mem_wr_data(mem_wr_data),
        .i_mem_rd_data(mem_rd_data), .o_oob(oob)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last       = 2;
        m_burst      = 0;
        m_burst_len  = 0;
        m_yield_due  = 0;
        exp_a_rvalid = 1'b0;
        exp_b_rvalid = 1'b0;
        exp_a_rd     = '0;
        exp_b_rd     = '0;
    endtask

    // 0 = nobody, 1 = A, 2 = B
    task automatic model_pick(output int win);
        win = 0;
        if (m_yield_due) begin
            if (a_req) win = 1;
            m_yield_due = 0;
        end else if (m_burst) begin
            if (b_req) win = 2;
            if (!b_req || !b_lock) begin
                m_burst     = 0;
                m_burst_len = 0;
            end else if (a_req) begin
                m_burst_len++;
                if (m_burst_len >= MAX_LOCK) begin
                    m_burst     = 0;
                    m_yield_due = 1;
                end
            end
        end else begin
            if (a_req && b_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                win = 1;
`else
                win = (m_last == 2) ? 1 : 2;
`endif
            end else if (a_req) win = 1;
            else if (b_req) win = 2;
            if (win == 2 && b_lock) begin
                m_burst_len = 1;
                if (a_req && MAX_LOCK <= 1) m_yield_due = 1;
                else m_burst = 1;
            end
        end
        if (win != 0) m_last = win;
    endtask

    task automatic step(input logic ar, input logic aw, input logic [15:0] aa, input logic [WL-1:0] ad,
                        input logic br, input logic bw, input logic [15:0] ba, input logic [WL-1:0] bd,
                        input logic bl);
        int          win;
        logic        w_wr;
        logic [15:0] w_addr;
        logic [WL-1:0] w_data;
        logic        w_oob;
        a_req = ar; a_wr_en = aw; a_addr = aa; a_wr_data = ad;
        b_req = br; b_wr_en = bw; b_addr = ba; b_wr_data = bd; b_lock = bl;
        @(negedge clk);
        obs_a_gnt = a_gnt; obs_b_gnt = b_gnt; obs_oob = oob; obs_wr = mem_wr_en;
        obs_a_rvalid = a_rvalid; obs_a_rd = a_rd_data;
        check("a_rvalid", a_rvalid, exp_a_rvalid);
        check("b_rvalid", b_rvalid, exp_b_rvalid);
        if (exp_a_rvalid) check("a_rd_data", a_rd_data, exp_a_rd);
        if (exp_b_rvalid) check("b_rd_data", b_rd_data, exp_b_rd);
        model_pick(win);
        last_win = win;
        w_wr   = (win == 2) ? bw : aw;
        w_addr = (win == 2) ? ba : aa;
        w_data = (win == 2) ? bd : ad;
        w_oob  = (win != 0) && (int'(w_addr) >= DEPTH);
        check("a_gnt", a_gnt, win == 1);
        check("b_gnt", b_gnt, win == 2);
        check("oob", oob, w_oob);
        check("mem_wr_en", mem_wr_en, (win != 0) && w_wr && !w_oob);
        if (win != 0) begin
            check("mem_addr", mem_addr, int'(w_addr) % DEPTH);
            if (w_wr) check("mem_wr_data", mem_wr_data, w_data);
        end else begin
            check("idle_mem_addr", mem_addr, 0);
            check("idle_mem_wr_data", mem_wr_data, 0);
        end
        exp_a_rvalid = (win == 1) && !w_wr;
        exp_b_rvalid = (win == 2) && !w_wr;
        if (win != 0 && !w_wr) begin
            if (win == 1) exp_a_rd = w_oob ? '0 : ref_mem[int'(w_addr) % DEPTH];
            else          exp_b_rd = w_oob ? '0 : ref_mem[int'(w_addr) % DEPTH];
        end
        if (win != 0 && w_wr && !w_oob) ref_mem[int'(w_addr)] = w_data;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_gnt"}, a_gnt, 0);
        check({tag, "_b_gnt"}, b_gnt, 0);
        check({tag, "_a_rvalid"}, a_rvalid, 0);
        check({tag, "_b_rvalid"}, b_rvalid, 0);
        check({tag, "_a_rd_data"}, a_rd_data, 0);
        check({tag, "_b_rd_data"}, b_rd_data, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wr_en"}, mem_wr_en, 0);
        check({tag, "_mem_wr_data"}, mem_wr_data, 0);
        check({tag, "_oob"}, oob, 0);
    endtask

    initial begin
        int na, nb;
        logic [WL-1:0] v, mem0;
        bit pa, pb;
        logic aw, bw, bl;
        logic [15:0] aa, ba;
        logic [WL-1:0] ad, bd;

        for (int i = 0; i < DEPTH; i++) begin
            v = WL'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end
        model_reset();

        // reset state, with a request already pending
        a_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // both ports read every cycle
        na = 0; nb = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 16'(10 + i), '0, 1, 0, 16'(20 + i), '0, 0);
            if (i == 0) check("first_conflict_a", obs_a_gnt, 1);
            na += int'(obs_a_gnt); nb += int'(obs_b_gnt);
        end
`ifdef MEM_ARB_FIXED_PRIO_EN
        check("fixed_a_count", na, 6);
        check("fixed_b_count", nb, 0);
`else
        check("alt_a_count", na, 3);
        check("alt_b_count", nb, 3);
`endif

        // write then read back at address 5
        step(1, 1, 16'd5, 16'h1234, 0, 0, '0, '0, 0);
        check("wr5_gnt", obs_a_gnt, 1);
        step(1, 0, 16'd5, '0, 0, 0, '0, '0, 0);
        check("rd5_gnt", obs_a_gnt, 1);
        check("rd5_no_rvalid_after_wr", obs_a_rvalid, 0);
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);
        check("rd5_rvalid", obs_a_rvalid, 1);
        check("rd5_data", obs_a_rd, 16'h1234);

        // out-of-range address
        mem0 = ref_mem[0];
        step(1, 1, 16'd1024, 16'hBEEF, 0, 0, '0, '0, 0);
        check("oob_wr_pulse", obs_oob, 1);
        check("oob_wr_dropped", obs_wr, 0);
        step(1, 0, 16'd1024, '0, 0, 0, '0, '0, 0);
        step(1, 0, 16'd0, '0, 0, 0, '0, '0, 0);
        check("oob_rd_zero", obs_a_rd, 0);
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);
        check("mem0_kept", obs_a_rd, mem0);

        // B locked write burst while A keeps requesting
        na = 0; nb = 0;
        for (int i = 0; i < 20; i++) begin
            step(i != 0, 0, 16'd100, '0, 1, 1, 16'(100 + i), WL'($urandom), 1);
            na += int'(obs_a_gnt); nb += int'(obs_b_gnt);
            if (i == 7) check("burst_b8", obs_b_gnt, 1);
            if (i == 8) check("yield_a", obs_a_gnt, 1);
        end
`ifdef MEM_ARB_FIXED_PRIO_EN
        check("lock_a_count", na, 12);
        check("lock_b_count", nb, 8);
`else
        check("lock_a_count", na, 2);
        check("lock_b_count", nb, 18);
`endif
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);

        // randomized traffic; requesters hold until granted
        pa = 0; pb = 0;
        aw = 0; bw = 0; bl = 0; aa = '0; ba = '0; ad = '0; bd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && $urandom_range(0, 3) != 0) begin
                pa = 1;
                aw = 1'($urandom);
                aa = ($urandom_range(0, 15) == 0) ? 16'(1024 + $urandom_range(0, 3000))
                                                  : 16'($urandom_range(0, 31));
                ad = WL'($urandom);
            end
            if (!pb && $urandom_range(0, 3) != 0) begin
                pb = 1;
                bw = 1'($urandom);
                ba = ($urandom_range(0, 15) == 0) ? 16'(1024 + $urandom_range(0, 3000))
                                                  : 16'($urandom_range(0, 31));
                bd = WL'($urandom);
            end
            bl = ($urandom_range(0, 4) != 0);
            step(pa, aw, aa, ad, pb, bw, ba, bd, bl);
            if (last_win == 1) pa = 0;
            if (last_win == 2) pb = 0;
        end

        // reset in the middle of a read
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);
        a_req = 1'b1; a_wr_en = 1'b0; a_addr = 16'd3;
        b_req = 1'b0; b_lock = 1'b0;
        @(negedge clk);
        check("pre_rst_gnt", a_gnt, 1);
        #1 rst = 1'b1;
        #1 check_all_zero("mid_rst");
        @(posedge clk);
        #1;
        a_req = 1'b0;
        rst = 1'b0;
        model_reset();
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);
        check("post_rst_no_rvalid", obs_a_rvalid, 0);
        step(1, 0, 16'd5, '0, 0, 0, '0, '0, 0);
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
